// File: rtl/sram_sync_ctrl.sv
// Synchronous single-port SRAM with registered read data and a post-reset zero-fill.
// While the zero-fill runs, the memory reports busy and discards every access.
module sram_sync_ctrl #(
  parameter int DW           = 8,
  parameter int AW           = 8,
  parameter int CLR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs_i,
  input  logic          wr_i,
  input  logic          rd_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          doutValid_o,
  output logic          busy_o,
  output logic          drop_o
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t        state_q;
  logic [AW-1:0] clrCnt_q;
  logic [AW-1:0] clrCnt_d;
  logic [DW-1:0] dout_q;
  logic          doutValid_q;
  logic          busy_q;
  logic          drop_q;
  logic          request;

  logic [DW-1:0] mem [DEPTH];

  assign request = cs_i & (wr_i | rd_i);

  always_comb begin
    clrCnt_d = clrCnt_q + 1'b1;
  end

  // A write arriving together with a read takes the port, so the read is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= (CLR_ON_RESET != 0) ? CLEAR : IDLE;
      busy_q      <= (CLR_ON_RESET != 0);
      clrCnt_q    <= '0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      doutValid_q <= 1'b0;
      drop_q      <= 1'b0;
      case (state_q)
        CLEAR: begin
          clrCnt_q <= clrCnt_d;
          drop_q   <= request;
          if (&clrCnt_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (cs_i && !wr_i && rd_i) begin
            dout_q      <= mem[addr_i];
            doutValid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage carries no reset; holding rst_n low keeps the array untouched.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) begin
        mem[clrCnt_q] <= '0;
      end else if (cs_i && wr_i) begin
        mem[addr_i] <= din_i;
      end
    end
  end

  assign dout_o      = dout_q;
  assign doutValid_o = doutValid_q;
  assign busy_o      = busy_q;
  assign drop_o      = drop_q;

endmodule

// File: tb/tb_sram_sync_ctrl.sv
// Randomised and directed bench for sram_sync_ctrl (DW=8, AW=4) against a
// transaction-level memory model.
module tb_sram_sync_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          cs;
  logic          wr;
  logic          rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          doutValid;
  logic          busy;
  logic          drop;

  int checks;
  int errors;

  logic [DW-1:0] modelMem [DEPTH];
  int            clearLeft;
  logic [DW-1:0] expDout;
  logic          expValid;
  logic          expDrop;

  sram_sync_ctrl #(.DW(DW), .AW(AW), .CLR_ON_RESET(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs_i        (cs),
    .wr_i        (wr),
    .rd_i        (rd),
    .addr_i      (addr),
    .din_i       (din),
    .dout_o      (dout),
    .doutValid_o (doutValid),
    .busy_o      (busy),
    .drop_o      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock of traffic: predict from the model, clock the DUT, compare.
  task automatic applyStimulus(input logic c, input logic w, input logic r,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    expValid = 1'b0;
    expDrop  = 1'b0;
    if (clearLeft > 0) begin
      expDrop = c & (w | r);
      clearLeft--;
      if (clearLeft == 0) begin
        for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
      end
    end else if (c && w) begin
      modelMem[a] = d;
    end else if (c && r) begin
      expDout  = modelMem[a];
      expValid = 1'b1;
    end
    cs = c; wr = w; rd = r; addr = a; din = d;
    @(posedge clk);
    #1;
    checkOutput("dout", 32'(dout), 32'(expDout));
    checkOutput("dout_valid", 32'(doutValid), 32'(expValid));
    checkOutput("busy", 32'(busy), 32'(clearLeft > 0));
    checkOutput("drop", 32'(drop), 32'(expDrop));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
    #3;
    checkOutput("reset dout", 32'(dout), 32'h0);
    checkOutput("reset dout_valid", 32'(doutValid), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h1);
    checkOutput("reset drop", 32'(drop), 32'h0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    clearLeft = DEPTH;
    expDout   = '0;
  endtask

  task automatic randomCycles(input int n, input bit allowCs);
    logic c;
    for (int i = 0; i < n; i++) begin
      c = allowCs ? ($urandom_range(0, 3) != 0) : 1'b0;
      applyStimulus(c, 1'(($urandom % 3) == 0), 1'($urandom), 4'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; din = '0;
    for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
    clearLeft = DEPTH;
    expDout   = '0;
    #12;
    applyReset();

    // Zero-fill: busy for exactly DEPTH cycles, then every word reads back zero.
    idleCycles(DEPTH);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b1, 4'(i), '0);

    applyStimulus(1'b1, 1'b1, 1'b0, 4'd3, 8'hA5);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd7, 8'h3C);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd3, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd7, '0);
    idleCycles(1);

    applyStimulus(1'b1, 1'b1, 1'b1, 4'd5, 8'h77);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd5, '0);

    // Read-after-write to the same address on the next cycle.
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd9, 8'h5E);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd9, '0);

    randomCycles(200, 1'b1);
    randomCycles(30, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b1, 4'(i), '0);

    // Reset arriving part way through the fill restarts it from word 0.
    applyReset();
    randomCycles(9, 1'b1);
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd2, 8'hFF);
    randomCycles(DEPTH - 1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd2, '0);
    randomCycles(100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
